// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular FIFO of fetched {inst, pc} between fetch and dispatch,
// presenting the head entry pre-split into decode fields with zero read latency.
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  output logic             enq_ready,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [11:0]      opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [15:0]      immediate,
  output logic [25:0]      address,
  output logic [31:0]      pc,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic enq_fire, deq_fire;
  logic [31:0] head;
  assign full = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign enq_fire = enq_valid & enq_ready & ~flush;
  assign deq_fire = deq_ready & deq_valid & ~flush;
  always_ff @(posedge clk)
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(enq_fire) - (PTR_W+1)'(deq_fire);
    end
  always_ff @(posedge clk)
    if (enq_fire) begin
      inst_mem[wr_ptr] <= enq_inst;
      pc_mem[wr_ptr] <= enq_pc;
    end
  // an empty queue shows all-zero fields so dispatch never decodes stale data
  assign head = empty ? '0 : inst_mem[rd_ptr];
  assign pc = empty ? '0 : pc_mem[rd_ptr];
  assign opcode = {head[31:26], head[31:26] == 6'd0 ? head[5:0] : 6'd0};
  assign rs = head[25:21];
  assign rt = head[20:16];
  assign rd = head[15:11];
  assign shamt = head[10:6];
  assign immediate = head[15:0];
  assign address = head[25:0];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed stimulus against a queue-based reference model,
// with per-cycle comparison plus literal expectations for key scenarios.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;
  logic clk = 0;
  logic rst = 1;
  logic enq_valid = 0;
  logic [31:0] enq_inst = 0;
  logic [31:0] enq_pc = 0;
  logic enq_ready;
  logic deq_ready = 0;
  logic deq_valid;
  logic [11:0] opcode;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic [25:0] address;
  logic [31:0] pc;
  logic flush = 0;
  logic [3:0] count;
  logic full, empty;
  int checks = 0;
  int failures = 0;
  bit live = 0;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;
  entry_t model[$];
  logic [31:0] out_pcs[$];

  inst_fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc),
    .enq_ready(enq_ready), .deq_ready(deq_ready), .deq_valid(deq_valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .immediate(immediate), .address(address),
    .pc(pc), .flush(flush), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: accept/remove decided from the queue size before the edge
  always @(posedge clk) begin
    int sz;
    bit do_enq, do_deq;
    sz = model.size();
    if (rst || flush) model.delete();
    else begin
      do_enq = enq_valid && sz < DEPTH;
      do_deq = deq_ready && sz > 0;
      if (do_deq) void'(model.pop_front());
      if (do_enq) model.push_back('{enq_inst, enq_pc});
    end
  end

  always @(negedge clk) begin
    logic [31:0] hi, hp;
    if (live) begin
      hi = model.size() > 0 ? model[0].inst : 32'd0;
      hp = model.size() > 0 ? model[0].pc : 32'd0;
      chk("m_count", 32'(count), 32'(model.size()));
      chk("m_bound", 32'(count <= 4'd8), 32'd1);
      chk("m_full", 32'(full), 32'(model.size() == DEPTH));
      chk("m_empty", 32'(empty), 32'(model.size() == 0));
      chk("m_enq_ready", 32'(enq_ready), 32'(model.size() != DEPTH));
      chk("m_deq_valid", 32'(deq_valid), 32'(model.size() != 0));
      chk("m_opcode", 32'(opcode), {20'd0, hi[31:26], (hi[31:26] == 0) ? hi[5:0] : 6'd0});
      chk("m_rs", 32'(rs), 32'(hi[25:21]));
      chk("m_rt", 32'(rt), 32'(hi[20:16]));
      chk("m_rd", 32'(rd), 32'(hi[15:11]));
      chk("m_shamt", 32'(shamt), 32'(hi[10:6]));
      chk("m_imm", 32'(immediate), 32'(hi[15:0]));
      chk("m_addr", 32'(address), 32'(hi[25:0]));
      chk("m_pc", pc, hp);
      if (deq_ready && deq_valid && !flush && !rst) out_pcs.push_back(pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit ev, input logic [31:0] ei, input logic [31:0] ep, input bit dr);
    enq_valid = ev;
    enq_inst = ei;
    enq_pc = ep;
    deq_ready = dr;
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    live = 1;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);
    chk("rst_deq_valid", 32'(deq_valid), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_pc", pc, 0);
    // single I-type entry
    set_in(1, 32'h2128000A, 5, 0);
    tick();
    set_in(0, 0, 0, 0);
    chk("one_deq_valid", 32'(deq_valid), 1);
    chk("one_opcode", 32'(opcode), 32'h200);
    chk("one_rs", 32'(rs), 9);
    chk("one_rt", 32'(rt), 8);
    chk("one_imm", 32'(immediate), 32'h000A);
    chk("one_pc", pc, 5);
    chk("one_count", 32'(count), 1);
    set_in(0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0);
    chk("one_drained", 32'(empty), 1);
    // fill, overflow attempt, then drain across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      set_in(1, 32'h0400_0000 * i + i, i, 0);
      tick();
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_enq_ready", 32'(enq_ready), 0);
    chk("fill_count", 32'(count), 8);
    set_in(1, 32'hFFFF_FFFF, 99, 0);
    tick();
    chk("fill_drop_count", 32'(count), 8);
    chk("fill_head_pc", pc, 0);
    out_pcs.delete();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 1);
      tick();
    end
    for (int i = 8; i < 11; i++) begin
      set_in(1, 32'h1000_0000 + i, i, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 1);
      tick();
    end
    set_in(0, 0, 0, 0);
    chk("wrap_n", out_pcs.size(), 11);
    for (int i = 0; i < 11 && i < out_pcs.size(); i++) chk("wrap_order", out_pcs[i], i);
    chk("wrap_empty", 32'(empty), 1);
    // steady state at count=4 with simultaneous enq/deq
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h2000_0000 + i, 100 + i, 0);
      tick();
    end
    out_pcs.delete();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 32'h2000_0000 + i, 104 + i, 1);
      tick();
      chk("steady_count", 32'(count), 4);
    end
    set_in(0, 0, 0, 0);
    chk("steady_n", out_pcs.size(), 10);
    for (int i = 0; i < 10 && i < out_pcs.size(); i++) chk("steady_order", out_pcs[i], 100 + i);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1);
      tick();
    end
    chk("steady_drained", 32'(empty), 1);
    // flush with concurrent enq/deq
    for (int i = 0; i < 5; i++) begin
      set_in(1, 32'h3000_0000 + i, 200 + i, 0);
      tick();
    end
    chk("pre_flush_count", 32'(count), 5);
    set_in(1, 32'hDEAD_BEEF, 32'hDEAD, 1);
    flush = 1;
    tick();
    flush = 0;
    set_in(0, 0, 0, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_pc", pc, 0);
    set_in(1, 32'h2128000A, 32'h40, 0);
    tick();
    chk("post_flush_pc", pc, 32'h40);
    chk("post_flush_count", 32'(count), 1);
    // R-type replaces the head via simultaneous enq/deq
    set_in(1, 32'h012A4020, 32'h44, 1);
    tick();
    chk("r_opcode", 32'(opcode), 32'h020);
    chk("r_rd", 32'(rd), 8);
    chk("r_shamt", 32'(shamt), 0);
    chk("r_rs", 32'(rs), 9);
    chk("r_rt", 32'(rt), 10);
    chk("r_pc", pc, 32'h44);
    for (int i = 0; i < 2; i++) begin
      set_in(1, 32'h0000_0000, 32'h48 + 4 * i, 0);
      tick();
    end
    set_in(0, 0, 0, 0);
    chk("r_count3", 32'(count), 3);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    // empty queue with both handshakes: only the enqueue lands
    set_in(1, 32'h2128000A, 32'h80, 1);
    tick();
    set_in(0, 0, 0, 0);
    chk("empty_both_count", 32'(count), 1);
    chk("empty_both_pc", pc, 32'h80);
    tick();
    live = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling FIFO between the PC/instruction-memory fetch path and the dispatch logic (RegFile/ROB/RS/AddressUnit).
- Buffers fetched instruction words together with their PC.
- Presents the head entry pre-split into the decode fields consumed by dispatch.
- Supports a single-cycle flush driven by the ROB on mispredict/exception.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- PTR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- enq_valid  in  1  fetch presents a valid instruction this cycle.
- enq_inst  in  32  fetched instruction word.
- enq_pc  in  32  PC of enq_inst.
- enq_ready  out  1  queue accepts an entry this cycle.
- deq_ready  in  1  dispatch consumes the head this cycle (driven low by dispatch when ROB/RS full).
- deq_valid  out  1  head entry is valid (queue not empty).
- opcode  out  12  {inst[31:26], inst[31:26]==0 ? inst[5:0] : 6'd0} of head.
- rs  out  5  head inst[25:21].
- rt  out  5  head inst[20:16].
- rd  out  5  head inst[15:11].
- shamt  out  5  head inst[10:6].
- immediate  out  16  head inst[15:0].
- address  out  26  head inst[25:0].
- pc  out  32  head PC.
- flush  in  1  ROB flush; discards all entries.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {inst, pc}.
  - head pointer rd_ptr, tail pointer wr_ptr, both PTR_W bits, wrap modulo DEPTH naturally.
  - Separate count register of PTR_W+1 bits.
- Reset (rst=1 at clk edge): rd_ptr=0, wr_ptr=0, count=0.
  - Entry contents are don't-care.
  - After reset: deq_valid=0, empty=1, full=0, enq_ready=1.
- Decode field outputs are combinational from the head entry (first-word fall-through, zero read latency).
  - When empty=1, all decode field outputs and pc are forced to 0. With opcode=0, dispatch logic sees no hlt.
- enq_ready = ~full. No write-through-when-full bypass, even if deq occurs the same cycle.
- deq_valid = ~empty.
- Handshakes per cycle:
  - enq_fire = enq_valid & enq_ready & ~flush.
  - deq_fire = deq_ready & deq_valid & ~flush.
- enq_fire: write {enq_inst, enq_pc} at wr_ptr; wr_ptr+1.
- deq_fire: rd_ptr+1.
- count update:
  - +1 if only enq_fire.
  - -1 if only deq_fire.
  - unchanged if both or neither.
- Enqueue latency: an entry enqueued into an empty queue appears on deq_valid/fields the next cycle. No same-cycle bypass from enq to outputs.
- Simultaneous enq and deq with 0<count<DEPTH: both happen; count is unchanged; head advances.
- Empty with enq_valid and deq_ready: only the enqueue takes effect (deq_valid=0).
- Full with enq_valid and deq_ready: only the dequeue takes effect; enq_ready=0, so fetch must hold its PC.
- Flush (flush=1 at clk edge): rd_ptr=0, wr_ptr=0, count=0.
  - Any same-cycle enq/deq is ignored.
  - flush has priority over enq/deq; rst has priority over flush.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble. FIFO order is preserved across the wrap.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when the pointers are equal and full.
- Assertion (bench): count never exceeds DEPTH and never underflows.

Test Plan:
- Reset then idle → count=0, empty=1, full=0, enq_ready=1, deq_valid=0, opcode=0, pc=0.
- Single enqueue, then dequeue:
  - Stimulus: enqueue inst=0x2128000A (addi rt=8, rs=9, imm=10), pc=5; hold deq_ready=0.
  - Next cycle: deq_valid=1, opcode=12'h200, rs=9, rt=8, immediate=16'h000A, pc=5, count=1.
  - Then deq_ready=1 for 1 cycle → empty=1.
- Fill and wrap:
  - Enqueue 8 entries with pc=0..7, no deq → full=1, enq_ready=0, count=8; a 9th enq_valid is dropped.
  - Dequeue 3 and enqueue pc=8,9,10 → dequeue order 3,4,...,10 with no gaps.
- Simultaneous enq+deq at count=4 for 10 cycles → count stays 4; the pc stream out equals the pc stream in, delayed by 4 entries.
- Flush:
  - Stimulus: count=5, then flush=1 together with enq_valid=1 and deq_ready=1.
  - Next cycle: count=0, empty=1; the enqueued entry is absent.
  - A following enqueue of pc=0x40 appears at the head.
- R-type decode: enqueue 0x012A4020 (add rd=8, rs=9, rt=10) → opcode=12'h020, rd=8, shamt=0. Assert rst mid-stream at count=3 → count=0 next cycle.
